// File: rtl/deparser_hdr_merge_pkg.sv
// Shared types and default sizing for the deparser header merge stage.
package deparser_hdr_merge_pkg;

  localparam int unsigned C_SEG_WIDTH_DEF = 512;
  localparam int unsigned C_HDR_BYTES_DEF = 256;
  localparam int unsigned C_ROW_W_DEF     = 7;

  typedef enum logic [1:0] {
    WrNone = 2'b00,
    Wr2B   = 2'b01,
    Wr4B   = 2'b10,
    Wr8B   = 2'b11
  } wr_type_e;

  // StFill zero-pads the beats skipped by an early s_hdr_last before merging.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StFill  = 3'd2,
    StMerge = 3'd3,
    StEmit  = 3'd4
  } state_e;

endpackage

// File: rtl/hdr_byte_bank.sv
// One byte-wide header bank: a single-row write port for field write-backs plus a
// whole-segment-slice write and read used for header load and emit.
module hdr_byte_bank #(
  parameter int unsigned C_ROW_W    = 7,
  parameter int unsigned C_ROWS     = 128,
  parameter int unsigned C_SEG_ROWS = 32,
  parameter int unsigned C_SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      i_seg_we,
  input  logic [C_SEL_W-1:0]        i_seg_wsel,
  input  logic [C_SEG_ROWS*8-1:0]   i_seg_wdata,
  input  logic [C_SEL_W-1:0]        i_seg_rsel,
  output logic [C_SEG_ROWS*8-1:0]   o_seg_rdata,
  input  logic                      i_wr_en,
  input  logic [C_ROW_W-1:0]        i_wr_row,
  input  logic [7:0]                i_wr_data
);

  logic [7:0] r_mem [C_ROWS];

  // Contents are deliberately not reset; every header fully overwrites them.
  always_ff @(posedge clk) begin
    if (i_seg_we) begin
      for (int k = 0; k < C_SEG_ROWS; k++) begin
        r_mem[C_ROW_W'(int'(i_seg_wsel) * C_SEG_ROWS + k)] <= i_seg_wdata[8*k +: 8];
      end
    end
    if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_data;
    end
  end

  always_comb begin
    o_seg_rdata = '0;
    for (int k = 0; k < C_SEG_ROWS; k++) begin
      o_seg_rdata[8*k +: 8] = r_mem[C_ROW_W'(int'(i_seg_rsel) * C_SEG_ROWS + k)];
    end
  end

endmodule

// File: rtl/deparser_hdr_merge.sv
// Header merge buffer: loads a header in segments, applies 2-byte field write-backs
// into even/odd byte banks, then streams the rebuilt header out in segments.
module deparser_hdr_merge
  import deparser_hdr_merge_pkg::*;
#(
  parameter int unsigned C_SEG_WIDTH = C_SEG_WIDTH_DEF,
  parameter int unsigned C_HDR_BYTES = C_HDR_BYTES_DEF,
  parameter int unsigned C_ROW_W     = C_ROW_W_DEF
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   s_hdr_valid,
  input  logic [C_SEG_WIDTH-1:0] s_hdr_data,
  input  logic                   s_hdr_last,
  output logic                   s_hdr_ready,
  input  logic                   wr_valid,
  input  logic [1:0]             wr_type,
  input  logic [7:0]             wr_byte_even,
  input  logic [7:0]             wr_byte_odd,
  input  logic [7:0]             wr_row_even,
  input  logic [7:0]             wr_row_odd,
  output logic                   wr_ready,
  input  logic                   merge_done,
  output logic                   m_hdr_valid,
  output logic [C_SEG_WIDTH-1:0] m_hdr_data,
  output logic                   m_hdr_last,
  input  logic                   m_hdr_ready,
  output logic                   err_type,
  output logic                   err_row
);

  localparam int unsigned C_BEATS    = C_HDR_BYTES * 8 / C_SEG_WIDTH;
  localparam int unsigned C_SEG_ROWS = C_SEG_WIDTH / 16;
  localparam int unsigned C_BEAT_W   = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_BEATS - 1);

  state_e                  r_state, w_state_d;
  logic [C_BEAT_W-1:0]     r_beat, w_beat_d;
  logic                    r_m_valid, r_m_last, r_err_type, r_err_row;
  logic [C_SEG_WIDTH-1:0]  r_m_data;

  logic                    w_in_fire, w_wr_fire, w_out_fire, w_wr_2b;
  logic                    w_seg_we, w_seg_zero;
  logic [C_BEAT_W-1:0]     w_rd_sel;
  logic [C_SEG_ROWS*8-1:0] w_even_wdata, w_odd_wdata, w_even_rdata, w_odd_rdata;
  logic [C_SEG_WIDTH-1:0]  w_rd_data;

  assign s_hdr_ready = aresetn && ((r_state == StIdle) || (r_state == StLoad));
  assign wr_ready    = aresetn && (r_state == StMerge);
  assign w_in_fire   = s_hdr_valid && s_hdr_ready;
  assign w_wr_fire   = wr_valid && wr_ready;
  assign w_wr_2b     = w_wr_fire && (wr_type == Wr2B);
  assign w_out_fire  = r_m_valid && m_hdr_ready;
  // Prefetch the next beat on the handshake so a ready sink sees no bubbles.
  assign w_rd_sel    = w_out_fire ? r_beat + 1'b1 : r_beat;

  assign m_hdr_valid = r_m_valid;
  assign m_hdr_data  = r_m_data;
  assign m_hdr_last  = r_m_last;
  assign err_type    = r_err_type;
  assign err_row     = r_err_row;

  always_comb begin
    w_state_d  = r_state;
    w_beat_d   = r_beat;
    w_seg_we   = 1'b0;
    w_seg_zero = 1'b0;
    unique case (r_state)
      StIdle, StLoad: begin
        if (w_in_fire) begin
          w_seg_we = 1'b1;
          if (r_beat == C_LAST_BEAT) begin
            w_state_d = StMerge;
            w_beat_d  = '0;
          end else begin
            w_beat_d  = r_beat + 1'b1;
            w_state_d = s_hdr_last ? StFill : StLoad;
          end
        end
      end
      StFill: begin
        w_seg_we   = 1'b1;
        w_seg_zero = 1'b1;
        if (r_beat == C_LAST_BEAT) begin
          w_state_d = StMerge;
          w_beat_d  = '0;
        end else begin
          w_beat_d = r_beat + 1'b1;
        end
      end
      StMerge: begin
        if (merge_done) begin
          w_state_d = StEmit;
        end
      end
      StEmit: begin
        if (w_out_fire) begin
          if (r_beat == C_LAST_BEAT) begin
            w_state_d = StIdle;
            w_beat_d  = '0;
          end else begin
            w_beat_d = r_beat + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    w_even_wdata = '0;
    w_odd_wdata  = '0;
    w_rd_data    = '0;
    for (int k = 0; k < C_SEG_ROWS; k++) begin
      w_even_wdata[8*k +: 8]   = w_seg_zero ? 8'h00 : s_hdr_data[16*k +: 8];
      w_odd_wdata[8*k +: 8]    = w_seg_zero ? 8'h00 : s_hdr_data[16*k+8 +: 8];
      w_rd_data[16*k +: 8]     = w_even_rdata[8*k +: 8];
      w_rd_data[16*k+8 +: 8]   = w_odd_rdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= StIdle;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_data   <= '0;
      r_err_type <= 1'b0;
      r_err_row  <= 1'b0;
    end else begin
      r_err_type <= w_wr_fire && ((wr_type == Wr4B) || (wr_type == Wr8B));
      r_err_row  <= w_wr_2b && (wr_row_even[7] || wr_row_odd[7]);
      if (r_state == StEmit) begin
        if (!r_m_valid) begin
          r_m_valid <= 1'b1;
          r_m_data  <= w_rd_data;
          r_m_last  <= (r_beat == C_LAST_BEAT);
        end else if (m_hdr_ready) begin
          if (r_beat == C_LAST_BEAT) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
          end else begin
            r_m_data <= w_rd_data;
            r_m_last <= (w_rd_sel == C_LAST_BEAT);
          end
        end
      end
    end
  end

  hdr_byte_bank #(
    .C_ROW_W    (C_ROW_W),
    .C_ROWS     (2 ** C_ROW_W),
    .C_SEG_ROWS (C_SEG_ROWS),
    .C_SEL_W    (C_BEAT_W)
  ) u_even_bank (
    .clk         (clk),
    .i_seg_we    (w_seg_we),
    .i_seg_wsel  (r_beat),
    .i_seg_wdata (w_even_wdata),
    .i_seg_rsel  (w_rd_sel),
    .o_seg_rdata (w_even_rdata),
    .i_wr_en     (w_wr_2b),
    .i_wr_row    (wr_row_even[C_ROW_W-1:0]),
    .i_wr_data   (wr_byte_even)
  );

  hdr_byte_bank #(
    .C_ROW_W    (C_ROW_W),
    .C_ROWS     (2 ** C_ROW_W),
    .C_SEG_ROWS (C_SEG_ROWS),
    .C_SEL_W    (C_BEAT_W)
  ) u_odd_bank (
    .clk         (clk),
    .i_seg_we    (w_seg_we),
    .i_seg_wsel  (r_beat),
    .i_seg_wdata (w_odd_wdata),
    .i_seg_rsel  (w_rd_sel),
    .o_seg_rdata (w_odd_rdata),
    .i_wr_en     (w_wr_2b),
    .i_wr_row    (wr_row_odd[C_ROW_W-1:0]),
    .i_wr_data   (wr_byte_odd)
  );

endmodule

// File: tb/tb_deparser_hdr_merge.sv
// Scoreboard bench for deparser_hdr_merge: a byte-array header model feeds expected
// output beats into a queue that a negedge monitor pops on every output handshake.
module tb_deparser_hdr_merge;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         s_hdr_valid, s_hdr_last, s_hdr_ready;
  logic [511:0] s_hdr_data;
  logic         wr_valid, wr_ready, merge_done;
  logic [1:0]   wr_type;
  logic [7:0]   wr_byte_even, wr_byte_odd, wr_row_even, wr_row_odd;
  logic         m_hdr_valid, m_hdr_last, m_hdr_ready;
  logic [511:0] m_hdr_data;
  logic         err_type, err_row;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } beat_t;

  beat_t      sb[$];
  beat_t      mon_exp;
  logic [7:0] src   [256];
  logic [7:0] model [256];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  deparser_hdr_merge u_dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_hdr_valid  (s_hdr_valid),
    .s_hdr_data   (s_hdr_data),
    .s_hdr_last   (s_hdr_last),
    .s_hdr_ready  (s_hdr_ready),
    .wr_valid     (wr_valid),
    .wr_type      (wr_type),
    .wr_byte_even (wr_byte_even),
    .wr_byte_odd  (wr_byte_odd),
    .wr_row_even  (wr_row_even),
    .wr_row_odd   (wr_row_odd),
    .wr_ready     (wr_ready),
    .merge_done   (merge_done),
    .m_hdr_valid  (m_hdr_valid),
    .m_hdr_data   (m_hdr_data),
    .m_hdr_last   (m_hdr_last),
    .m_hdr_ready  (m_hdr_ready),
    .err_type     (err_type),
    .err_row      (err_row)
  );

  // Output handshake monitor; inputs change at posedge+2 so negedge values are stable.
  always @(negedge clk) begin
    if (aresetn === 1'b1 && m_hdr_valid === 1'b1 && m_hdr_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected_beat got last=%0b with empty scoreboard", m_hdr_last);
      end else begin
        mon_exp = sb.pop_front();
        if (m_hdr_data !== mon_exp.data || m_hdr_last !== mon_exp.last) begin
          failures++;
          $display("FAIL out_beat got last=%0b data=%h want last=%0b data=%h",
                   m_hdr_last, m_hdr_data, mon_exp.last, mon_exp.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_expected();
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 64; j++) b.data[8*j +: 8] = model[64*i + j];
      b.last = (i == 3);
      sb.push_back(b);
    end
  endtask

  // Sends nbeats segments from src, s_hdr_last on the final one; model zero-fills the rest.
  task automatic send_hdr(input int nbeats);
    int n;
    for (int i = 0; i < 256; i++) model[i] = (i < nbeats * 64) ? src[i] : 8'h00;
    for (int i = 0; i < nbeats; i++) begin
      for (int j = 0; j < 64; j++) s_hdr_data[8*j +: 8] = src[64*i + j];
      s_hdr_valid = 1'b1;
      s_hdr_last  = (i == nbeats - 1);
      n = 0;
      while (s_hdr_ready !== 1'b1 && n < 50) begin step(); n++; end
      if (s_hdr_ready !== 1'b1) begin
        checks++; failures++;
        $display("FAIL s_hdr_ready_timeout got %b want 1", s_hdr_ready);
      end
      step();
    end
    s_hdr_valid = 1'b0;
    s_hdr_last  = 1'b0;
  endtask

  task automatic do_write(input logic v, input logic [1:0] t, input logic [7:0] re,
                          input logic [7:0] ro, input logic [7:0] be, input logic [7:0] bo,
                          input logic done);
    int n = 0;
    wr_valid = v; wr_type = t; wr_row_even = re; wr_row_odd = ro;
    wr_byte_even = be; wr_byte_odd = bo; merge_done = done;
    while (wr_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (wr_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wr_ready_timeout got %b want 1", wr_ready);
    end
    step();
    wr_valid = 1'b0; wr_type = 2'b00; merge_done = 1'b0;
    if (v && t == 2'b01) begin
      model[{re[6:0], 1'b0}] = be;
      model[{ro[6:0], 1'b1}] = bo;
    end
    if (done) push_expected();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin step(); n++; end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d beats pending want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step(); step();
    checks++;
    if ({m_hdr_valid, m_hdr_last, err_type, err_row, s_hdr_ready, wr_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got v=%b l=%b et=%b er=%b sr=%b wr=%b want all 0",
               m_hdr_valid, m_hdr_last, err_type, err_row, s_hdr_ready, wr_ready);
    end
    checks++;
    if (m_hdr_data !== 512'h0) begin
      failures++;
      $display("FAIL reset_data got %h want 0", m_hdr_data);
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (s_hdr_ready !== 1'b1 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready got sr=%b wr=%b want sr=1 wr=0", s_hdr_ready, wr_ready);
    end
    // Write-back and merge_done in IDLE must be ignored.
    wr_valid = 1'b1; wr_type = 2'b10; merge_done = 1'b1;
    step();
    wr_valid = 1'b0; wr_type = 2'b00; merge_done = 1'b0;
    checks++;
    if (err_type !== 1'b0 || s_hdr_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ignore_wr got et=%b sr=%b want et=0 sr=1", err_type, s_hdr_ready);
    end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 256; i++) src[i] = 8'(i);
    send_hdr(4);
    do_write(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checks++;
    if (m_hdr_valid !== 1'b0 || s_hdr_ready !== 1'b0) begin
      failures++;
      $display("FAIL pass_emit_entry got v=%b sr=%b want v=0 sr=0", m_hdr_valid, s_hdr_ready);
    end
    step();
    checks++;
    if (m_hdr_valid !== 1'b1) begin
      failures++;
      $display("FAIL pass_first_valid got %b want 1", m_hdr_valid);
    end
    wait_drain("pass");
    checks++;
    if (m_hdr_valid !== 1'b0 || s_hdr_ready !== 1'b1) begin
      failures++;
      $display("FAIL pass_back_to_idle got v=%b sr=%b want v=0 sr=1", m_hdr_valid, s_hdr_ready);
    end
  endtask

  task automatic test_even_write();
    for (int i = 0; i < 256; i++) src[i] = 8'(i) ^ 8'h5A;
    send_hdr(4);
    do_write(1'b1, 2'b01, 8'd5, 8'd5, 8'hAB, 8'hCD, 1'b0);
    checks++;
    if (err_type !== 1'b0 || err_row !== 1'b0) begin
      failures++;
      $display("FAIL even_no_err got et=%b er=%b want 0 0", err_type, err_row);
    end
    do_write(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_drain("even");
  endtask

  task automatic test_odd_write();
    for (int i = 0; i < 256; i++) src[i] = 8'(255 - i);
    send_hdr(4);
    do_write(1'b1, 2'b01, 8'd6, 8'd5, 8'h11, 8'h22, 1'b0);
    do_write(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_drain("odd");
  endtask

  task automatic test_done_overwrite();
    for (int i = 0; i < 256; i++) src[i] = 8'(i * 3);
    send_hdr(4);
    do_write(1'b1, 2'b01, 8'h7F, 8'h7F, 8'h01, 8'h02, 1'b0);
    do_write(1'b1, 2'b01, 8'h7F, 8'h7F, 8'hEE, 8'hFF, 1'b1);
    wait_drain("done_ovw");
  endtask

  task automatic test_early_last_err_stall();
    beat_t held;
    int n = 0;
    for (int i = 0; i < 256; i++) src[i] = 8'(i) | 8'h80;
    send_hdr(2);
    checks++;
    if (s_hdr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_ready got %b want 0", s_hdr_ready);
    end
    do_write(1'b1, 2'b10, 8'd3, 8'd3, 8'h99, 8'h99, 1'b0);
    checks++;
    if (err_type !== 1'b1 || err_row !== 1'b0) begin
      failures++;
      $display("FAIL err_type_pulse got et=%b er=%b want 1 0", err_type, err_row);
    end
    do_write(1'b1, 2'b01, 8'h80, 8'h45, 8'h77, 8'h88, 1'b0);
    checks++;
    if (err_type !== 1'b0 || err_row !== 1'b1) begin
      failures++;
      $display("FAIL err_row_pulse got et=%b er=%b want 0 1", err_type, err_row);
    end
    do_write(1'b1, 2'b01, 8'h50, 8'h60, 8'h3C, 8'hC3, 1'b1);
    checks++;
    if (err_type !== 1'b0 || err_row !== 1'b0) begin
      failures++;
      $display("FAIL err_single_pulse got et=%b er=%b want 0 0", err_type, err_row);
    end
    while (sb.size() != 2 && n < 50) begin step(); n++; end
    m_hdr_ready = 1'b0;
    held.data = m_hdr_data;
    held.last = m_hdr_last;
    checks++;
    if (sb.size() != 2 || m_hdr_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_setup got pending=%0d v=%b want 2 1", sb.size(), m_hdr_valid);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (m_hdr_valid !== 1'b1 || m_hdr_data !== held.data || m_hdr_last !== held.last) begin
        failures++;
        $display("FAIL stall_hold got v=%b l=%b data=%h want v=1 l=%b data=%h",
                 m_hdr_valid, m_hdr_last, m_hdr_data, held.last, held.data);
      end
    end
    m_hdr_ready = 1'b1;
    wait_drain("early");
  endtask

  task automatic test_reset_mid_emit();
    int n = 0;
    for (int i = 0; i < 256; i++) src[i] = 8'(i + 17);
    send_hdr(4);
    do_write(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    while (sb.size() != 2 && n < 50) begin step(); n++; end
    aresetn = 1'b0;
    step();
    checks++;
    if (m_hdr_valid !== 1'b0 || m_hdr_last !== 1'b0 || m_hdr_data !== 512'h0 ||
        s_hdr_ready !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got v=%b l=%b sr=%b wr=%b want 0 0 0 0",
               m_hdr_valid, m_hdr_last, s_hdr_ready, wr_ready);
    end
    checks++;
    if (sb.size() != 2) begin
      failures++;
      $display("FAIL midreset_beats_emitted got pending=%0d want 2", sb.size());
    end
    sb.delete();
    aresetn = 1'b1;
    #1;
    checks++;
    if (s_hdr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_release got sr=%b want 1", s_hdr_ready);
    end
    for (int i = 0; i < 256; i++) src[i] = 8'(i * 7 + 1);
    send_hdr(4);
    do_write(1'b1, 2'b01, 8'h20, 8'h21, 8'hA5, 8'h5A, 1'b1);
    wait_drain("after_reset");
  endtask

  initial begin
    aresetn = 1'b0; s_hdr_valid = 1'b0; s_hdr_last = 1'b0; s_hdr_data = '0;
    wr_valid = 1'b0; wr_type = 2'b00; wr_byte_even = '0; wr_byte_odd = '0;
    wr_row_even = '0; wr_row_odd = '0; merge_done = 1'b0; m_hdr_ready = 1'b1;
    test_reset();
    test_pass_through();
    test_even_write();
    test_odd_write();
    test_done_overwrite();
    test_early_last_err_stall();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
